// File: rtl/channel_read_arb_pkg.sv
// rtl/channel_read_arb_pkg.sv - shared types and constants for the channel read arbiter
package channel_read_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

    localparam int LEN_LSB   = 0;
    localparam int LEN_MSB   = 8;
    localparam int LEN_W     = LEN_MSB - LEN_LSB + 1;
    localparam int WL_W      = 10;
    localparam int HDR_WORDS = 2;
    localparam int MAX_WORDS = 126;

    // Byte length to word count, widened first so 511+3 does not wrap.
    function automatic logic [WL_W-1:0] len_to_words(input logic [LEN_W-1:0] len);
        logic [WL_W-1:0] sum;
        sum = {1'b0, len} + 10'd3;
        return sum >> 2;
    endfunction

endpackage

// File: rtl/channel_read_arb_rr_arb4.sv
// rtl/channel_read_arb_rr_arb4.sv - combinational 4-way round-robin arbiter
module rr_arb4 (
    input  logic [3:0] request,
    input  logic [1:0] last,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);

    logic [1:0] cand;

    // Search starts one past the previous winner; the previous winner is checked last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (request[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/channel_read_arb.sv
// rtl/channel_read_arb.sv - round-robin packet reader from per-channel show-ahead buffers
module channel_read_arb #(
    parameter int NUM_CHAN  = 4,
    parameter int MAX_WORDS = channel_read_arb_pkg::MAX_WORDS
) (
    input  logic                     txclk,
    input  logic                     reset,
    input  logic [NUM_CHAN-1:0]      chan_en,
    input  logic [NUM_CHAN-1:0]      pkt_waiting,
    input  logic [32*NUM_CHAN-1:0]   buf_data,
    output logic [NUM_CHAN-1:0]      buf_rd,
    output logic [NUM_CHAN-1:0]      buf_rd_done,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [1:0]               out_chan,
    output logic                     len_err
);

    import channel_read_arb_pkg::*;

    localparam logic [WL_W-1:0] MAX_BYTES = WL_W'(MAX_WORDS * 4);

    state_t          state, state_nx;
    logic [1:0]      sel, last_grant;
    logic [WL_W-1:0] words_left;
    logic            grant_valid;
    logic [1:0]      grant_idx;
    logic            hs;
    logic [LEN_W-1:0] hdr_len;
    logic            len_over;

    rr_arb4 u_arb (
        .request     (pkt_waiting & chan_en),
        .last        (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign out_data = buf_data[{sel, 5'd0} +: 32];
    assign out_chan = sel;
    assign hs       = out_valid & out_ready;
    assign hdr_len  = out_data[LEN_MSB:LEN_LSB];
    assign len_over = {1'b0, hdr_len} > MAX_BYTES;

    always_ff @(posedge txclk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sel        <= 2'd0;
            last_grant <= 2'd3;
            words_left <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE:    if (grant_valid) sel <= grant_idx;
                ST_HDR0:    if (hs) words_left <= len_to_words(hdr_len);
                ST_PAYLOAD: if (hs) words_left <= words_left - 1'b1;
                ST_DONE:    last_grant <= sel;
                default:    ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (grant_valid) state_nx = ST_HDR0;
            ST_HDR0:    if (hs) state_nx = len_over ? ST_DONE : ST_HDR1;
            ST_HDR1:    if (hs) state_nx = (words_left != '0) ? ST_PAYLOAD : ST_DONE;
            ST_PAYLOAD: if (hs && words_left <= WL_W'(1)) state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid   = 1'b0;
        out_sop     = 1'b0;
        out_eop     = 1'b0;
        len_err     = 1'b0;
        buf_rd      = '0;
        buf_rd_done = '0;
        case (state)
            ST_HDR0: begin
                out_valid = 1'b1;
                out_sop   = 1'b1;
                out_eop   = len_over;
                len_err   = len_over & out_ready;
            end
            ST_HDR1: begin
                out_valid = 1'b1;
                out_eop   = (words_left == '0);
            end
            ST_PAYLOAD: begin
                out_valid = 1'b1;
                out_eop   = (words_left == WL_W'(1));
            end
            ST_DONE:   buf_rd_done = NUM_CHAN'(1) << sel;
            default:   ;
        endcase
        if (hs) buf_rd = NUM_CHAN'(1) << sel;
    end

endmodule

// File: tb/tb_channel_read_arb.sv
// tb/tb_channel_read_arb.sv - directed self-checking bench for channel_read_arb
module tb_channel_read_arb;

    logic         txclk = 1'b0;
    logic         reset;
    logic [3:0]   chan_en;
    logic [3:0]   pkt_waiting;
    logic [127:0] buf_data;
    logic [3:0]   buf_rd;
    logic [3:0]   buf_rd_done;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sop;
    logic         out_eop;
    logic [1:0]   out_chan;
    logic         len_err;

    channel_read_arb dut (
        .txclk       (txclk),
        .reset       (reset),
        .chan_en     (chan_en),
        .pkt_waiting (pkt_waiting),
        .buf_data    (buf_data),
        .buf_rd      (buf_rd),
        .buf_rd_done (buf_rd_done),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_chan    (out_chan),
        .len_err     (len_err)
    );

    always #5 txclk = ~txclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Buffer model: packets are preloaded, read pointer advances on buf_rd.
    logic [31:0] mem [4][64];
    int wr_ptr [4];
    int pk_loaded [4];
    int rd_ptr [4];
    int done_cnt [4];

    always @(posedge txclk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                rd_ptr[i]   <= 0;
                done_cnt[i] <= 0;
            end else begin
                if (buf_rd[i])      rd_ptr[i]   <= rd_ptr[i] + 1;
                if (buf_rd_done[i]) done_cnt[i] <= done_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pkt_waiting[i]     = pk_loaded[i] > done_cnt[i];
            buf_data[32*i +: 32] = mem[i][rd_ptr[i] & 63];
        end
    end

    // Monitor: log handshakes, releases and strobes; check stability across stalls.
    int          cyc;
    logic [31:0] w_data [$];
    bit          w_sop [$];
    bit          w_eop [$];
    int          w_cyc [$];
    int          s_chan [$];
    int          d_chan [$];
    int          d_cyc [$];
    int          n_lenerr;
    int          n_rd;
    bit          stall_seen;
    logic [31:0] stall_data;
    bit          stall_eop;

    always @(negedge txclk) begin
        if (reset) begin
            stall_seen = 1'b0;
        end else begin
            cyc++;
            if (stall_seen && out_valid) begin
                check("stall_data", out_data, stall_data);
                check("stall_eop", 32'(out_eop), 32'(stall_eop));
            end
            stall_seen = out_valid && !out_ready;
            stall_data = out_data;
            stall_eop  = out_eop;
            if (out_valid && out_ready) begin
                w_data.push_back(out_data);
                w_sop.push_back(out_sop);
                w_eop.push_back(out_eop);
                w_cyc.push_back(cyc);
                if (out_sop) s_chan.push_back(int'(out_chan));
            end
            if (buf_rd != 4'd0) n_rd++;
            for (int i = 0; i < 4; i++)
                if (buf_rd_done[i]) begin
                    d_chan.push_back(i);
                    d_cyc.push_back(cyc);
                end
            if (len_err) n_lenerr++;
        end
    end

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic begin_scn();
        reset     = 1'b1;
        out_ready = 1'b1;
        chan_en   = 4'hF;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            wr_ptr[i]    = 0;
            pk_loaded[i] = 0;
        end
        w_data.delete(); w_sop.delete(); w_eop.delete(); w_cyc.delete();
        s_chan.delete(); d_chan.delete(); d_cyc.delete();
        cyc = 0; n_lenerr = 0; n_rd = 0;
    endtask

    task automatic load_pkt(input int ch, input int len, input int id);
        int nw;
        nw = (len <= 504) ? (len + 3) / 4 : 0;
        mem[ch][wr_ptr[ch]]     = (id << 16) | len;
        mem[ch][wr_ptr[ch] + 1] = 32'hA100_0000 | (id << 8);
        for (int k = 0; k < nw; k++)
            mem[ch][wr_ptr[ch] + 2 + k] = 32'hD000_0000 | (id << 8) | k;
        wr_ptr[ch]    = wr_ptr[ch] + 2 + nw;
        pk_loaded[ch] = pk_loaded[ch] + 1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            wr_ptr[i] = 0;
            pk_loaded[i] = 0;
            for (int k = 0; k < 64; k++) mem[i][k] = 32'h0;
        end
        begin_scn();
        @(negedge txclk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_buf_rd", 32'(buf_rd), 0);
        check("rst_buf_rd_done", 32'(buf_rd_done), 0);
        check("rst_flags", {29'd0, out_sop, out_eop, len_err}, 0);
        check("rst_out_chan", 32'(out_chan), 0);
        tick();

        // Single 8-byte packet on channel 0.
        load_pkt(0, 8, 1);
        reset = 1'b0;
        run(12);
        check("s1_words", w_data.size(), 4);
        check("s1_w0", w_data[0], 32'h0001_0008);
        check("s1_sop0", 32'(w_sop[0]), 1);
        check("s1_eop0", 32'(w_eop[0]), 0);
        check("s1_w3", w_data[3], 32'hD000_0101);
        check("s1_eop3", 32'(w_eop[3]), 1);
        check("s1_first_cyc", w_cyc[0], 2);
        check("s1_done_n", d_chan.size(), 1);
        check("s1_done_ch", d_chan[0], 0);
        check("s1_done_cyc", d_cyc[0], 6);

        // All four channels busy: two 4-byte packets each.
        begin_scn();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) load_pkt(c, 4, 16 * p + c);
        reset = 1'b0;
        run(50);
        check("s2_pkts", s_chan.size(), 8);
        for (int i = 0; i < 5; i++) check("s2_order", s_chan[i], i % 4);
        for (int i = 1; i < 8; i++) check("s2_no_repeat", 32'(s_chan[i] != s_chan[i-1]), 1);
        check("s2_dones", d_chan.size(), 8);

        // Zero-length packet on channel 2.
        begin_scn();
        load_pkt(2, 0, 3);
        reset = 1'b0;
        run(10);
        check("s3_words", w_data.size(), 2);
        check("s3_sop0", 32'(w_sop[0]), 1);
        check("s3_eop0", 32'(w_eop[0]), 0);
        check("s3_eop1", 32'(w_eop[1]), 1);
        check("s3_done_ch", d_chan[0], 2);
        check("s3_done_cyc", d_cyc[0], w_cyc[1] + 1);

        // Oversize length on channel 1.
        begin_scn();
        load_pkt(1, 505, 4);
        reset = 1'b0;
        run(10);
        check("s4_words", w_data.size(), 1);
        check("s4_w0", w_data[0], 32'h0004_01F9);
        check("s4_sop_eop", {30'd0, w_sop[0], w_eop[0]}, 3);
        check("s4_len_err", n_lenerr, 1);
        check("s4_done_n", d_chan.size(), 1);
        check("s4_done_ch", d_chan[0], 1);

        // 20-byte packet with out_ready toggling.
        begin_scn();
        load_pkt(0, 20, 5);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            out_ready = i[0];
            tick();
        end
        out_ready = 1'b1;
        check("s5_rd_pulses", n_rd, 7);
        check("s5_words", w_data.size(), 7);
        check("s5_last", w_data[6], 32'hD000_0504);
        check("s5_eop_last", 32'(w_eop[6]), 1);
        check("s5_done_n", d_chan.size(), 1);

        // Only channels 1 and 3 enabled.
        begin_scn();
        for (int c = 0; c < 4; c++) load_pkt(c, 4, 32 + c);
        chan_en = 4'b1010;
        reset = 1'b0;
        run(30);
        check("s6_pkts", s_chan.size(), 2);
        check("s6_ch_a", s_chan[0], 1);
        check("s6_ch_b", s_chan[1], 3);
        check("s6_words", w_data.size(), 6);

        // Reset while channel 2 is mid-payload.
        begin_scn();
        load_pkt(2, 20, 6);
        reset = 1'b0;
        run(4);
        check("s7_in_payload", {30'd0, out_valid, out_sop}, 2);
        reset = 1'b1;
        tick();
        @(negedge txclk);
        check("s7_out_valid", 32'(out_valid), 0);
        check("s7_buf_rd", 32'(buf_rd), 0);
        check("s7_buf_rd_done", 32'(buf_rd_done), 0);
        check("s7_flags", {29'd0, out_sop, out_eop, len_err}, 0);
        check("s7_out_chan", 32'(out_chan), 0);
        check("s7_no_done", d_chan.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/channel_read_arb.md
CHANNEL_READ_ARB -- requirements
Module: channel_read_arb

Interface
REQ-001 Parameter NUM_CHAN, default 4: number of channel buffers served; fixed at 4 in this revision.
REQ-002 Parameter MAX_WORDS, default 126: maximum payload words per packet, i.e. 504 bytes.
REQ-003 txclk  input  1  the single clock; every register samples on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 chan_en  input  4  per-channel enable; a disabled channel is never granted.
REQ-006 pkt_waiting  input  4  per channel, set when that buffer holds at least one complete packet.
REQ-007 buf_data  input  128  show-ahead read data; channel i occupies bits [32i+31:32i].
REQ-008 buf_rd  output  4  per-channel read-advance strobe.
REQ-009 buf_rd_done  output  4  per-channel end-of-packet strobe; releases the buffer slot.
REQ-010 out_data  output  32  forwarded word.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_sop  output  1  word is header word 0.
REQ-014 out_eop  output  1  word is the last forwarded word of the packet.
REQ-015 out_chan  output  2  index of the channel currently granted.
REQ-016 len_err  output  1  one-cycle pulse when a header length exceeds MAX_WORDS*4.

Function
REQ-017 The FSM SHALL have five states:
- IDLE: arbitrate among the requesting channels.
- HDR0 and HDR1: forward the two header words.
- PAYLOAD: forward the payload words.
- DONE: release the buffer slot.
REQ-018 IDLE SHALL grant a channel when pkt_waiting[i] & chan_en[i]:
- round-robin, starting from last_grant+1;
- grant registers into sel and the FSM moves to HDR0 on the next cycle;
- with no requester the FSM stays in IDLE.
REQ-019 out_valid SHALL be high only in HDR0, HDR1 and PAYLOAD, with out_data = buf_data[sel].
REQ-020 buf_rd[sel] SHALL equal out_valid & out_ready; all other bits are 0.
- No state advances without this handshake.
REQ-021 On the HDR0 handshake, length = out_data[8:0] in bytes; words_left = (length+3)>>2 is computed in 10-bit arithmetic with no truncation.
REQ-022 HDR0 SHALL transition to HDR1 on the handshake.
REQ-023 On the HDR1 handshake the FSM SHALL go to PAYLOAD when words_left>0, else to DONE.
- out_eop SHALL be high on the HDR1 word when words_left==0.
REQ-024 In PAYLOAD, each handshake SHALL decrement words_left.
- out_eop SHALL be high when words_left==1.
- The handshake at words_left==1 SHALL go to DONE.
REQ-025 If length > MAX_WORDS*4, on the HDR0 handshake:
- len_err pulses for one cycle;
- the FSM goes directly to DONE, so HDR1 and the payload are not forwarded;
- that HDR0 word carries out_eop=1.
REQ-026 DONE SHALL last exactly one cycle:
- buf_rd_done[sel]=1 and buf_rd=0;
- last_grant<=sel;
- next state is IDLE.
REQ-027 A channel just released SHALL NOT be regranted in the cycle after DONE, because that cycle is IDLE arbitration using pkt_waiting sampled after release.
REQ-028 Minimum packet cost SHALL be 2 + words + 2 cycles (IDLE, header words, payload words, DONE) when out_ready is held high.
REQ-029 Deasserting chan_en[sel] mid-packet SHALL NOT abort the packet; it only affects later grants.
REQ-030 out_ready low SHALL stall the FSM indefinitely while out_data and the flags are held stable.

Reset
REQ-031 On reset the block SHALL enter IDLE with all strobes and flags low:
- state=IDLE; sel=0; last_grant=3, so channel 0 is first; words_left=0;
- buf_rd=0, buf_rd_done=0, out_valid=0, out_sop=0, out_eop=0, len_err=0, out_chan=0.
REQ-032 Reset mid-packet SHALL abort the packet with no buf_rd_done issued; buffers are reset alongside.

Structure
REQ-033 A shared package SHALL hold:
- the state enum;
- the header length field position [8:0];
- the HDR_WORDS=2 and MAX_WORDS constants.
REQ-034 Arbitration SHALL be a single sub-module, rr_arb4: request[3:0] and last[1:0] in, grant_valid and grant_idx[1:0] out, purely combinational.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Ch0 waiting, header length=8, out_ready=1 -> 4 words out: sop on word 1, eop on word 4, buf_rd_done[0] on the cycle after word 4.
- Ch0–3 all waiting continuously -> grant order 0,1,2,3,0; no channel is served twice in a row.
- Length=0 -> 2 words with eop on the second word, then DONE.
- Length=505 -> 1 word with sop and eop, len_err=1 once, buf_rd_done issued, no further words.
- out_ready toggling 1/0 during PAYLOAD with length=20 -> exactly 7 buf_rd pulses; data stable while stalled.
- chan_en=4'b1010 with all waiting -> only channels 1 and 3 are served; reset mid-payload -> next cycle IDLE with all outputs 0.
